load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: 3-state bus FSM with byte/half/word lane steering and load extension.
// Optional access timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int width          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [2:0]       funct3,
  input  logic [width-1:0] ALUResult,
  input  logic [width-1:0] WriteData,
  output logic [width-1:0] ReadData,
  output logic             stall,
  output logic             misaligned,
  output logic             bus_error,
  output logic             mem_req,
  output logic             mem_we,
  output logic [width-1:0] mem_addr,
  output logic [width-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic             mem_ready,
  input  logic [width-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [width-1:0] rdata_q;
  logic [2:0]       funct3_q;
  logic [1:0]       offset_q;

  logic access;
  logic size_word;
  logic size_half;
  logic misalign_now;

  // funct3[1] set means word; this folds the reserved encodings into word accesses
  assign access       = MemRead | MemWrite;
  assign size_word    = funct3[1];
  assign size_half    = (funct3[1:0] == 2'b01);
  assign misalign_now = (size_word && (ALUResult[1:0] != 2'b00)) || (size_half && ALUResult[0]);

  assign mem_req = (state == BUSY);
  assign stall   = (state == BUSY) || ((state == IDLE) && access && !misalign_now);

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] busy_count;
  logic          bus_error_q;
  assign bus_error = bus_error_q;
`else
  assign bus_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata_q    <= '0;
      funct3_q   <= 3'b000;
      offset_q   <= 2'b00;
      misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      busy_count  <= '0;
      bus_error_q <= 1'b0;
`endif
    end else begin
      misaligned <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      bus_error_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (access) begin
            if (misalign_now) begin
              misaligned <= 1'b1;
            end else begin
              state    <= BUSY;
              mem_addr <= {ALUResult[width-1:2], 2'b00};
              mem_we   <= MemWrite;
              funct3_q <= funct3;
              offset_q <= ALUResult[1:0];
              rdata_q  <= '0;
`ifdef LSU_TIMEOUT_EN
              busy_count <= '0;
`endif
              if (!MemWrite || size_word) begin
                mem_be    <= 4'b1111;
                mem_wdata <= WriteData;
              end else if (size_half) begin
                mem_be    <= ALUResult[1] ? 4'b1100 : 4'b0011;
                mem_wdata <= {(width/16){WriteData[15:0]}};
              end else begin
                mem_be    <= 4'b0001 << ALUResult[1:0];
                mem_wdata <= {(width/8){WriteData[7:0]}};
              end
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            rdata_q <= mem_rdata;
            state   <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (busy_count == CW'(TIMEOUT_CYCLES - 1)) begin
            bus_error_q <= 1'b1;
            state       <= DONE;
          end else begin
            busy_count <= busy_count + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [7:0]       lane_byte;
  logic [15:0]      lane_half;
  logic [width-1:0] load_ext;

  // Extension uses the funct3 and low address bits captured when the access started
  always_comb begin
    lane_byte = rdata_q[{offset_q, 3'b000} +: 8];
    lane_half = offset_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{(width-8){lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{(width-16){lane_half[15]}}, lane_half};
      3'b100:  load_ext = {{(width-8){1'b0}}, lane_byte};
      3'b101:  load_ext = {{(width-16){1'b0}}, lane_half};
      default: load_ext = rdata_q;
    endcase
    ReadData = ((state == DONE) && !mem_we) ? load_ext : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: loads, stores, misalignment, wait states and reset.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult, WriteData, ReadData;
  logic        stall, misaligned, bus_error;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int fails  = 0;

  load_store_unit #(.width(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
    .stall(stall), .misaligned(misaligned), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd);
    MemRead   = rd;
    MemWrite  = wr;
    funct3    = f3;
    ALUResult = addr;
    WriteData = wd;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " mem_req"},    32'(mem_req),    32'h0);
    checkOutput({tag, " mem_we"},     32'(mem_we),     32'h0);
    checkOutput({tag, " mem_be"},     32'(mem_be),     32'h0);
    checkOutput({tag, " mem_addr"},   mem_addr,        32'h0);
    checkOutput({tag, " mem_wdata"},  mem_wdata,       32'h0);
    checkOutput({tag, " ReadData"},   ReadData,        32'h0);
    checkOutput({tag, " stall"},      32'(stall),      32'h0);
    checkOutput({tag, " misaligned"}, 32'(misaligned), 32'h0);
    checkOutput({tag, " bus_error"},  32'(bus_error),  32'h0);
  endtask

  // One aligned access from IDLE through BUSY (with wait states) to DONE and back to IDLE
  task automatic doAccess(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                          input int waits, input logic [31:0] expAddr, input logic [3:0] expBe,
                          input logic [31:0] expWdata, input logic expWe, input logic [31:0] expRead);
    int stallCycles = 0;
    applyStimulus(rd, wr, f3, addr, wd);
    mem_rdata = rdata;
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, " idle stall"}, 32'(stall), 32'h1);
    checkOutput({tag, " idle req"}, 32'(mem_req), 32'h0);
    if (stall) stallCycles++;
    nextCycle();
    applyStimulus(1'b1, ~wr, 3'b111, 32'hFFFF_FFFF, 32'h5555_5555);
    for (int i = 0; i <= waits; i++) begin
      mem_ready = (i == waits);
      @(negedge clk);
      checkOutput({tag, " busy req"}, 32'(mem_req), 32'h1);
      checkOutput({tag, " busy addr"}, mem_addr, expAddr);
      checkOutput({tag, " busy be"}, 32'(mem_be), 32'(expBe));
      checkOutput({tag, " busy we"}, 32'(mem_we), 32'(expWe));
      if (expWe) checkOutput({tag, " busy wdata"}, mem_wdata, expWdata);
      if (stall) stallCycles++;
      nextCycle();
    end
    mem_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput({tag, " done stall"}, 32'(stall), 32'h0);
    checkOutput({tag, " done req"}, 32'(mem_req), 32'h0);
    checkOutput({tag, " done bus_error"}, 32'(bus_error), 32'h0);
    if (!expWe) checkOutput({tag, " ReadData"}, ReadData, expRead);
    checkOutput({tag, " stall cycles"}, 32'(stallCycles), 32'(waits + 2));
    nextCycle();
    @(negedge clk);
    checkOutput({tag, " idle ReadData"}, ReadData, 32'h0);
    checkOutput({tag, " idle stall after"}, 32'(stall), 32'h0);
    nextCycle();
  endtask

  task automatic doMisaligned(input string tag, input logic [2:0] f3, input logic [31:0] addr);
    applyStimulus(1'b1, 1'b0, f3, addr, 32'h0);
    @(negedge clk);
    checkOutput({tag, " stall"}, 32'(stall), 32'h0);
    checkOutput({tag, " req"}, 32'(mem_req), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput({tag, " pulse"}, 32'(misaligned), 32'h1);
    checkOutput({tag, " req after"}, 32'(mem_req), 32'h0);
    checkOutput({tag, " ReadData"}, ReadData, 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput({tag, " pulse end"}, 32'(misaligned), 32'h0);
    checkOutput({tag, " req idle"}, 32'(mem_req), 32'h0);
    nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    @(negedge clk);
    checkAllZero("reset");
    nextCycle();
    reset_n = 1'b1;

    // Loads with lane selection and extension
    doAccess("LW 0x100",  1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 32'h100, 4'hF, 0, 0, 32'hDEADBEEF);
    doAccess("LB 0x103",  1, 0, 3'b000, 32'h103, 0, 32'h80FFFF7F, 0, 32'h100, 4'hF, 0, 0, 32'hFFFFFF80);
    doAccess("LBU 0x103", 1, 0, 3'b100, 32'h103, 0, 32'h80FFFF7F, 0, 32'h100, 4'hF, 0, 0, 32'h00000080);
    doAccess("LBU 0x100", 1, 0, 3'b100, 32'h100, 0, 32'h80FFFF7F, 1, 32'h100, 4'hF, 0, 0, 32'h0000007F);
    doAccess("LB 0x101",  1, 0, 3'b000, 32'h101, 0, 32'h80FFFF7F, 0, 32'h100, 4'hF, 0, 0, 32'hFFFFFFFF);
    doAccess("LH 0x102",  1, 0, 3'b001, 32'h102, 0, 32'h80011234, 2, 32'h100, 4'hF, 0, 0, 32'hFFFF8001);
    doAccess("LHU 0x100", 1, 0, 3'b101, 32'h100, 0, 32'h1234F00D, 0, 32'h100, 4'hF, 0, 0, 32'h0000F00D);
    doAccess("LW rsvd",   1, 0, 3'b011, 32'h010, 0, 32'h87654321, 0, 32'h010, 4'hF, 0, 0, 32'h87654321);

    // Stores with byte enables and lane replication
    doAccess("SH 0x202",  0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 32'h200, 4'b1100, 32'hABCDABCD, 1, 0);
    doAccess("SH 0x200",  0, 1, 3'b001, 32'h200, 32'h0000BEEF, 0, 1, 32'h200, 4'b0011, 32'hBEEFBEEF, 1, 0);
    doAccess("SB 0x301",  0, 1, 3'b000, 32'h301, 32'hAABBCCEF, 0, 0, 32'h300, 4'b0010, 32'hEFEFEFEF, 1, 0);
    doAccess("SW 0x404",  0, 1, 3'b010, 32'h404, 32'hCAFEF00D, 0, 3, 32'h404, 4'b1111, 32'hCAFEF00D, 1, 0);
    doAccess("RW both",   1, 1, 3'b010, 32'h500, 32'h11223344, 0, 0, 32'h500, 4'b1111, 32'h11223344, 1, 0);

    // Misaligned accesses never reach the bus
    doMisaligned("LW 0x101 misaligned", 3'b010, 32'h101);
    doMisaligned("LH 0x103 misaligned", 3'b001, 32'h103);
    doMisaligned("rsvd 0x012 misaligned", 3'b110, 32'h012);

    // Reset abandons a stalled access
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    mem_ready = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("wait busy req", 32'(mem_req), 32'h1);
      checkOutput("wait bus_error", 32'(bus_error), 32'h0);
      nextCycle();
    end
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD0BAD;
    nextCycle();
    @(negedge clk);
    checkAllZero("reset busy");
    mem_ready = 1'b0;
    reset_n   = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("post reset ReadData", ReadData, 32'h0);
    checkOutput("post reset req", 32'(mem_req), 32'h0);
    nextCycle();

`ifdef LSU_TIMEOUT_EN
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    mem_ready = 1'b0;
    mem_rdata = 32'h12345678;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("timeout busy req", 32'(mem_req), 32'h1);
      checkOutput("timeout busy bus_error", 32'(bus_error), 32'h0);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("timeout bus_error", 32'(bus_error), 32'h1);
    checkOutput("timeout req", 32'(mem_req), 32'h0);
    checkOutput("timeout ReadData", ReadData, 32'h0);
    checkOutput("timeout stall", 32'(stall), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("timeout bus_error end", 32'(bus_error), 32'h0);
    nextCycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
